// File: rtl/nn_pkg.sv
// Shared definitions for the small CNN pipeline.
// Holds the conv2 feature-map geometry consumed by the pooling stage, the
// row-parity state type used by maxpool_layer_2, and a width helper.
package nn_pkg;

  localparam int CONV2_CHANNELS = 16;
  localparam int CONV2_OUT_W    = 8;
  localparam int CONV2_OUT_H    = 8;

  // Which row of a 2x2 window is streaming in: the first (even) row is
  // stashed, the second (odd) row completes the window.
  typedef enum logic {
    ROW_EVEN = 1'b0,
    ROW_ODD  = 1'b1
  } row_state_e;

  // Counter/address width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// OUT_WIDTH-deep register file holding the horizontally pooled pairs of an
// even row until the matching odd row arrives.
// Ports:
//   clk, rst_n   clock, async active-low reset (clears every entry)
//   we           write enable (even-row, odd-column beat)
//   waddr/wdata  write port
//   raddr        combinational read address
//   rdata        combinational read data
module pool_line_buffer
  import nn_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  localparam int AW   = clog2_min1(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;

  // One flop bank per entry so each entry gets its own decoded enable.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        mem[i] <= '0;
      else if (we && (waddr == AW'(i)))
        mem[i] <= wdata;
    end
  end

  // Out-of-range addresses (only possible for non-power-of-two depths)
  // read as zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++)
      if (raddr == AW'(i)) rdata = mem[i];
  end

endmodule

// File: rtl/maxpool_layer_2.sv
// Binary 2x2 / stride-2 max-pool downstream of conv_layer_2.
// Input is a raster stream of CHANNELS-bit pixels (one per valid beat); on
// {0,1} data max == OR, so each pooled bit is the OR of its 2x2 window.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   valid_in          conv2_in holds a pixel this cycle (no backpressure)
//   conv2_in          channel bits of one pixel position
//   pool_out          pooled pixel, held between pulses
//   valid_out_pool    one-cycle pulse per pooled pixel, 1 clk after the beat
//                     completing its window
//   frame_done_pool   pulses with the last pooled pixel of a frame
module maxpool_layer_2
  import nn_pkg::*;
#(
  parameter int CHANNELS  = CONV2_CHANNELS,
  parameter int IN_WIDTH  = CONV2_OUT_W,
  parameter int IN_HEIGHT = CONV2_OUT_H
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_in,
  input  logic [CHANNELS-1:0] conv2_in,
  output logic [CHANNELS-1:0] pool_out,
  output logic                valid_out_pool,
  output logic                frame_done_pool
);

  localparam int OUT_WIDTH  = IN_WIDTH / 2;
  localparam int OUT_HEIGHT = IN_HEIGHT / 2;
  localparam int LB_DEPTH   = (OUT_WIDTH > 0) ? OUT_WIDTH : 1;
  localparam int AW         = clog2_min1(LB_DEPTH);
  localparam int CW         = clog2_min1(IN_WIDTH);
  localparam int RW         = clog2_min1(IN_HEIGHT);

  logic [CW-1:0]       col_cnt;
  logic [RW-1:0]       row_cnt;
  logic [CHANNELS-1:0] h_reg;
  row_state_e          state;

  logic                last_col, last_row, odd_col, last_pool_px;
  logic [CHANNELS-1:0] pair, lb_rdata;
  logic [AW-1:0]       lb_addr;
  logic                lb_we;

  assign last_col = (col_cnt == CW'(IN_WIDTH - 1));
  assign last_row = (row_cnt == RW'(IN_HEIGHT - 1));
  // An odd IN_WIDTH makes the trailing column even, so it never pairs.
  assign odd_col  = col_cnt[0];
  assign pair     = h_reg | conv2_in;
  assign lb_addr  = AW'(col_cnt >> 1);
  assign lb_we    = valid_in && odd_col && (state == ROW_EVEN);

  // Bottom-right pixel of the last complete window; a trailing unpaired
  // row/column lies beyond it.
  assign last_pool_px = (col_cnt == CW'(2 * OUT_WIDTH - 1)) &&
                        (row_cnt == RW'(2 * OUT_HEIGHT - 1));

  pool_line_buffer #(
    .DEPTH (LB_DEPTH),
    .WIDTH (CHANNELS)
  ) u_lb (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (pair),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

  // Raster counters; a frame wraps straight into the next with no idle beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (valid_in) begin
      if (last_col) begin
        col_cnt <= '0;
        row_cnt <= last_row ? '0 : row_cnt + RW'(1);
      end else begin
        col_cnt <= col_cnt + CW'(1);
      end
    end
  end

  // Left half of each horizontal pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      h_reg <= '0;
    else if (valid_in && !odd_col)
      h_reg <= conv2_in;
  end

  // Row-parity FSM with the registered output stage. An odd IN_HEIGHT
  // leaves the final row in ROW_EVEN, so it only fills the line buffer and
  // never emits; the frame wrap then forces ROW_EVEN regardless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ROW_EVEN;
      pool_out        <= '0;
      valid_out_pool  <= 1'b0;
      frame_done_pool <= 1'b0;
    end else begin
      valid_out_pool  <= 1'b0;
      frame_done_pool <= 1'b0;
      if (valid_in) begin
        if (state == ROW_ODD && odd_col) begin
          pool_out        <= lb_rdata | pair;
          valid_out_pool  <= 1'b1;
          frame_done_pool <= last_pool_px;
        end
        if (last_col) begin
          if (last_row)
            state <= ROW_EVEN;
          else
            state <= (state == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool_layer_2.sv
module tb_maxpool_layer_2;

  localparam int CH = 16;
  localparam int W  = 8;
  localparam int H  = 8;

  typedef struct {
    logic [CH-1:0] data;
    logic          fd;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_in = 1'b0;
  logic [CH-1:0] conv2_in = '0;
  logic [CH-1:0] pool_out;
  logic          valid_out_pool;
  logic          frame_done_pool;

  int n_checks = 0;
  int n_err    = 0;
  int pulses   = 0;
  logic [CH-1:0] img [H][W];
  exp_t q[$];

  always #5 clk = ~clk;

  maxpool_layer_2 #(.CHANNELS(CH), .IN_WIDTH(W), .IN_HEIGHT(H)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .valid_in        (valid_in),
    .conv2_in        (conv2_in),
    .pool_out        (pool_out),
    .valid_out_pool  (valid_out_pool),
    .frame_done_pool (frame_done_pool)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every pulse is matched against the head of the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && valid_out_pool) begin
        pulses++;
        if (q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL unexpected_pulse: pool_out %h with empty scoreboard", pool_out);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("pool_out", 32'(pool_out), 32'(e.data));
          chk("frame_done", 32'(frame_done_pool), 32'(e.fd));
        end
      end else if (rst_n && frame_done_pool) begin
        n_checks++; n_err++;
        $display("FAIL frame_done_without_valid: got 1, expected 0");
      end
    end
  end

  // Reference: the pooled pixel (r/2, c/2) is the OR of the 2x2 window and
  // becomes due once its bottom-right pixel has been delivered.
  task automatic beat(input int r, input int c);
    @(negedge clk);
    valid_in = 1'b1;
    conv2_in = img[r][c];
    if ((r % 2 == 1) && (c % 2 == 1) && r < 2 * (H / 2) && c < 2 * (W / 2)) begin
      exp_t e;
      e.data = img[r-1][c-1] | img[r-1][c] | img[r][c-1] | img[r][c];
      e.fd   = (r / 2 == H / 2 - 1) && (c / 2 == W / 2 - 1);
      q.push_back(e);
    end
  endtask

  // Idle cycles; after the first one nothing may pulse.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i > 0) chk("no_pulse_in_gap", 32'(valid_out_pool), 32'd0);
      valid_in = 1'b0;
      conv2_in = CH'($urandom);
    end
  endtask

  task automatic send_frame(input bit gaps, input bit chk_lat);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        beat(r, c);
        if (chk_lat && r == 1 && c == 1) begin
          @(posedge clk); #1;
          chk("latency_1clk", 32'(valid_out_pool), 32'd1);
        end
        if (gaps) idle($urandom_range(0, 3));
      end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    @(negedge clk);
    valid_in = 1'b0;
    while (q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk(name, 32'(q.size()), 32'd0);
    idle(2);
  endtask

  task automatic fill_const(input logic [CH-1:0] v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = v;
  endtask

  task automatic fill_single();
    fill_const('0);
    img[2][5] = 16'h0004;
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_pool_out"}, 32'(pool_out), 32'd0);
    chk({name, "_valid"}, 32'(valid_out_pool), 32'd0);
    chk({name, "_frame_done"}, 32'(frame_done_pool), 32'd0);
  endtask

  initial begin
    int p0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_hold");
    rst_n = 1'b1;

    // 1: all-zero frame
    fill_const('0);
    p0 = pulses;
    send_frame(0, 0);
    drain("t1_drain");
    chk("t1_count", 32'(pulses - p0), 32'd16);

    // 2: single set bit
    fill_single();
    p0 = pulses;
    send_frame(0, 0);
    drain("t2_drain");
    chk("t2_count", 32'(pulses - p0), 32'd16);

    // 3: checkerboard with latency check
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = ((r ^ c) & 1) ? 16'hFFFF : 16'h0000;
    p0 = pulses;
    send_frame(0, 1);
    drain("t3_drain");
    chk("t3_count", 32'(pulses - p0), 32'd16);

    // 4: test 2 with random gaps
    fill_single();
    p0 = pulses;
    send_frame(1, 0);
    drain("t4_drain");
    chk("t4_count", 32'(pulses - p0), 32'd16);

    // 5: reset after 20 beats of a random frame, then a clean frame
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = CH'($urandom);
    for (int b = 0; b < 20; b++) beat(b / W, b % W);
    @(negedge clk);
    rst_n = 1'b0;
    valid_in = 1'b0;
    #1;
    check_reset_outputs("midreset");
    chk("midreset_queue", 32'(q.size()), 32'd0);
    repeat (2) @(negedge clk);
    check_reset_outputs("midreset_hold");
    rst_n = 1'b1;
    fill_single();
    p0 = pulses;
    send_frame(0, 0);
    drain("t5_drain");
    chk("t5_count", 32'(pulses - p0), 32'd16);

    // 6: two back-to-back frames, all ones then all zeros
    p0 = pulses;
    fill_const('1);
    send_frame(0, 0);
    fill_const('0);
    send_frame(0, 0);
    drain("t6_drain");
    chk("t6_count", 32'(pulses - p0), 32'd32);

    // Random data and random gaps, a few frames
    for (int f = 0; f < 4; f++) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) img[r][c] = CH'($urandom) & CH'($urandom);
      p0 = pulses;
      send_frame(f[0], 0);
      drain("rand_drain");
      chk("rand_count", 32'(pulses - p0), 32'd16);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
